// File: rtl/icache_refill_ctrl.sv
// Refill controller for an 8-way set-associative cache with per-set tree-PLRU replacement.
// Optional macro ICACHE_REFILL_INVALID_FIRST_EN: prefer the lowest-index invalid way as victim.
module icache_refill_ctrl #(
    parameter int SETS   = 64,
    parameter int SET_W  = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = 4,
    localparam int BEAT_W = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit_valid,
    input  logic [SET_W-1:0]  hit_set,
    input  logic [7:0]        hit_way,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [SET_W-1:0]  miss_set,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [7:0]        way_valid,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [7:0]        mem_req_len,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_last,
    output logic [7:0]        fill_wen,
    output logic [SET_W-1:0]  fill_set,
    output logic [BEAT_W-1:0] fill_beat,
    output logic [DATA_W-1:0] fill_data,
    output logic              done_valid,
    output logic [7:0]        done_way,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [6:0]          plru_r [SETS];
    logic [SET_W-1:0]    set_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          victim_r;
    logic [BEAT_W:0]     cnt_r;       // MSB set once BEATS beats were written
    logic                accept_s;
    logic                beat_s;
    logic                hit_apply_s;
    logic [7:0]          victim_s;

    function automatic logic [7:0] plru_victim(input logic [6:0] t);
        logic [2:0] idx;
        logic [2:0] p;
        idx[2] = t[0];
        idx[1] = t[0] ? t[2] : t[1];
        p      = {1'b0, idx[2:1]} + 3'd3;
        idx[0] = t[p];
        return 8'd1 << idx;
    endfunction

    function automatic logic [2:0] way_index(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Point every node on the path away from way w.
    function automatic logic [6:0] plru_touch(input logic [6:0] t, input logic [2:0] w);
        logic [6:0] n;
        logic [2:0] p;
        n    = t;
        n[0] = ~w[2];
        if (w[2]) begin
            n[2] = ~w[1];
        end else begin
            n[1] = ~w[1];
        end
        p    = {1'b0, w[2:1]} + 3'd3;
        n[p] = ~w[0];
        return n;
    endfunction

`ifdef ICACHE_REFILL_INVALID_FIRST_EN
    logic [7:0] invalid_s;

    // Victim choice at accept: lowest invalid way, else PLRU walk.
    always_comb begin
        invalid_s = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (!way_valid[i]) begin
                invalid_s = 8'd1 << i;
            end
        end
        if (way_valid != 8'hFF) begin
            victim_s = invalid_s;
        end else begin
            victim_s = plru_victim(plru_r[miss_set]);
        end
    end
`else
    logic unused_way_valid_s;
    assign unused_way_valid_s = ^way_valid;

    // Victim choice at accept: PLRU walk of the registered tree.
    always_comb begin
        victim_s = plru_victim(plru_r[miss_set]);
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        beat_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (miss_valid) begin
                    accept_s = 1'b1;
                    state_s  = S_REQ;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_s = S_FILL;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_FILL: begin
                if (mem_rsp_valid) begin
                    beat_s = 1'b1;
                    if (mem_rsp_last) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_FILL;
                    end
                end else begin
                    state_s = S_FILL;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Latch the miss context and count fill beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_r    <= '0;
            addr_r   <= '0;
            victim_r <= 8'h00;
            cnt_r    <= '0;
        end else if (accept_s) begin
            set_r    <= miss_set;
            addr_r   <= miss_addr;
            victim_r <= victim_s;
            cnt_r    <= '0;
        end else if (beat_s && !cnt_r[BEAT_W]) begin
            cnt_r    <= cnt_r + (BEAT_W+1)'(1);
        end
    end

    // A hit colliding with the DONE update on the same set is dropped.
    assign hit_apply_s = hit_valid && (hit_way != 8'h00) &&
                         !((state_r == S_DONE) && (hit_set == set_r));

    // Replacement state: hit touches and refill-complete touch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SETS; i++) begin
                plru_r[i] <= 7'h00;
            end
        end else begin
            if (hit_apply_s) begin
                plru_r[hit_set] <= plru_touch(plru_r[hit_set], way_index(hit_way));
            end
            if (state_r == S_DONE) begin
                plru_r[set_r] <= plru_touch(plru_r[set_r], way_index(victim_r));
            end
        end
    end

    assign miss_ready    = (state_r == S_IDLE);
    assign busy          = (state_r != S_IDLE);
    assign mem_req_valid = (state_r == S_REQ);
    assign mem_req_addr  = addr_r;
    assign mem_req_len   = 8'(BEATS - 1);
    assign fill_wen      = (beat_s && !cnt_r[BEAT_W]) ? victim_r : 8'h00;
    assign fill_set      = set_r;
    assign fill_beat     = cnt_r[BEAT_W-1:0];
    assign fill_data     = mem_rsp_data;
    assign done_valid    = (state_r == S_DONE);
    assign done_way      = victim_r;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: vector table of misses plus directed corner sequences,
// with fill writes and done pulses checked against scoreboard queues.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hit_valid = 1'b0;
    logic [5:0]  hit_set = 6'd0;
    logic [7:0]  hit_way = 8'h00;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [5:0]  miss_set = 6'd0;
    logic [31:0] miss_addr = 32'd0;
    logic [7:0]  way_valid = 8'hFF;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic [7:0]  mem_req_len;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = 64'd0;
    logic        mem_rsp_last = 1'b0;
    logic [7:0]  fill_wen;
    logic [5:0]  fill_set;
    logic [1:0]  fill_beat;
    logic [63:0] fill_data;
    logic        done_valid;
    logic [7:0]  done_way;
    logic        busy;

    icache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_set(miss_set),
        .miss_addr(miss_addr), .way_valid(way_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last),
        .fill_wen(fill_wen), .fill_set(fill_set), .fill_beat(fill_beat), .fill_data(fill_data),
        .done_valid(done_valid), .done_way(done_way), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_fill = 0;
    logic [79:0] fill_q [$];
    logic [7:0]  done_q [$];

    typedef struct {
        logic [5:0]  set;
        logic [31:0] addr;
        logic [7:0]  wv;
        logic [7:0]  exp_way;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop expected fill writes and done victims as the DUT produces them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fill_wen != 8'h00) begin
                n_fill++;
                if (fill_q.size() == 0) begin
                    check("fill_unexpected", {88'd0, fill_wen}, 96'd0);
                end else begin
                    check("fill_write", {16'd0, fill_wen, fill_beat, fill_set, fill_data},
                          {16'd0, fill_q.pop_front()});
                end
            end
            if (done_valid) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", {95'd0, done_valid}, 96'd0);
                end else begin
                    check("done_way", {88'd0, done_way}, {88'd0, done_q.pop_front()});
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_hit(input logic [5:0] s, input logic [7:0] w);
        hit_valid = 1'b1; hit_set = s; hit_way = w;
        @(posedge clk); #1;
        hit_valid = 1'b0;
    endtask

    task automatic do_miss(input logic [5:0] s, input logic [31:0] a, input logic [7:0] wv,
                           input logic [7:0] exp_v, input int req_delay, input int n_beats,
                           input bit hit_en, input logic [5:0] hs, input logic [7:0] hw);
        int guard;
        logic [63:0] d;
        guard = 0;
        while (!miss_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("miss_ready_idle", {95'd0, miss_ready}, 96'd1);
        miss_valid = 1'b1; miss_set = s; miss_addr = a; way_valid = wv;
        done_q.push_back(exp_v);
        @(posedge clk); #1;
        miss_valid = 1'b0;
        check("req_valid", {95'd0, mem_req_valid}, 96'd1);
        check("req_addr", {64'd0, mem_req_addr}, {64'd0, a});
        check("req_len", {88'd0, mem_req_len}, 96'd3);
        for (int i = 0; i < req_delay; i++) begin
            @(posedge clk); #1;
            check("req_hold", {62'd0, mem_req_valid, miss_ready, busy, mem_req_addr},
                  {62'd0, 1'b1, 1'b0, 1'b1, a});
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int b = 0; b < n_beats; b++) begin
            d = {a, 32'(b) ^ 32'hA5A5_0000};
            mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_last = (b == n_beats - 1);
            if (b < 4) fill_q.push_back({exp_v, 2'(b), s, d});
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
        check("done_pulse", {95'd0, done_valid}, 96'd1);
        if (hit_en) begin
            hit_valid = 1'b1; hit_set = hs; hit_way = hw;
        end
        @(posedge clk); #1;
        hit_valid = 1'b0;
        check("after_done", {93'd0, miss_ready, busy, done_valid}, {93'd0, 3'b100});
    endtask

    initial begin
        int f0;
        vecs[0] = '{6'd9, 32'h9000, 8'hFF, 8'h01};
        vecs[1] = '{6'd9, 32'h9040, 8'hFF, 8'h10};
        vecs[2] = '{6'd9, 32'h9080, 8'hFF, 8'h04};
        vecs[3] = '{6'd9, 32'h90C0, 8'hFF, 8'h40};
        vecs[4] = '{6'd9, 32'h9100, 8'hFF, 8'h02};
        vecs[5] = '{6'd9, 32'h9140, 8'hFF, 8'h20};
        vecs[6] = '{6'd9, 32'h9180, 8'hFF, 8'h08};
        vecs[7] = '{6'd9, 32'h91C0, 8'hFF, 8'h80};

        #2;
        check("reset_outputs", {88'd0, miss_ready, busy, mem_req_valid, done_valid, 4'd0},
              {88'd0, 8'b1000_0000});
        check("reset_fill_wen", {88'd0, fill_wen}, 96'd0);
        do_reset();
        check("reset_addr_way", {56'd0, mem_req_addr, done_way}, 96'd0);
        check("reset_plru3", {89'd0, dut.plru_r[3]}, 96'd0);

        // Basic refill of set 3, then the second victim in that set.
        do_miss(6'd3, 32'h1000, 8'hFF, 8'h01, 0, 4, 1'b0, 6'd0, 8'h00);
        check("plru3_after", {89'd0, dut.plru_r[3]}, {89'd0, 7'h0B});
        do_miss(6'd3, 32'h1040, 8'hFF, 8'h10, 0, 4, 1'b0, 6'd0, 8'h00);

        // Vector table: eight back-to-back misses to one set.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_miss(vecs[i].set, vecs[i].addr, vecs[i].wv, vecs[i].exp_way, 0, 4, 1'b0, 6'd0, 8'h00);
        end

        // A hit steers the following victim away.
        do_reset();
        do_hit(6'd5, 8'h01);
        do_miss(6'd5, 32'h5000, 8'hFF, 8'h10, 0, 4, 1'b0, 6'd0, 8'h00);

        // Stalled request with an early last beat, then surplus beats dropped.
        do_reset();
        f0 = n_fill;
        do_miss(6'd1, 32'h2222_0000, 8'hFF, 8'h01, 10, 2, 1'b0, 6'd0, 8'h00);
        check("early_last_fills", 96'(n_fill - f0), 96'd2);
        f0 = n_fill;
        do_miss(6'd1, 32'h2222_0040, 8'hFF, 8'h10, 0, 6, 1'b0, 6'd0, 8'h00);
        check("overrun_fills", 96'(n_fill - f0), 96'd4);

        // Hit colliding with DONE on the same set is dropped; other set is applied.
        do_reset();
        do_miss(6'd2, 32'h3000, 8'hFF, 8'h01, 0, 4, 1'b1, 6'd2, 8'h10);
        check("collide_plru2", {89'd0, dut.plru_r[2]}, {89'd0, 7'h0B});
        do_reset();
        do_miss(6'd2, 32'h3000, 8'hFF, 8'h01, 0, 4, 1'b1, 6'd7, 8'h10);
        check("both_plru2", {89'd0, dut.plru_r[2]}, {89'd0, 7'h0B});
        check("both_plru7", {89'd0, dut.plru_r[7]}, {89'd0, 7'h24});

        // Invalid-way preference (or its absence).
        do_reset();
`ifdef ICACHE_REFILL_INVALID_FIRST_EN
        do_miss(6'd4, 32'h4000, 8'hF7, 8'h08, 0, 4, 1'b0, 6'd0, 8'h00);
        do_miss(6'd4, 32'h4040, 8'hFF, 8'h10, 0, 4, 1'b0, 6'd0, 8'h00);
`else
        do_miss(6'd4, 32'h4000, 8'hF7, 8'h01, 0, 4, 1'b0, 6'd0, 8'h00);
`endif

        // Reset in the middle of a fill: no done pulse, replacement state cleared.
        do_reset();
        do_hit(6'd6, 8'h01);
        miss_valid = 1'b1; miss_set = 6'd6; miss_addr = 32'h6000; way_valid = 8'hFF;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_state", {92'd0, busy, mem_req_valid, done_valid, miss_ready}, {92'd0, 4'b0001});
        check("abort_plru6", {89'd0, dut.plru_r[6]}, 96'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        check("fill_q_empty", 96'(fill_q.size()), 96'd0);
        check("done_q_empty", 96'(done_q.size()), 96'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss handler for an 8-way set-associative cache that owns the per-set tree-PLRU replacement state. On a miss it selects a victim way, issues a line-fill burst request to memory, steers returning beats into the victim way, and then updates replacement state. It sits between the cache lookup pipeline, which supplies hit and miss events, and the memory-side read port.

## Interface
- SETS, 64, number of cache sets
- SET_W, 6, set index width (log2 SETS)
- ADDR_W, 32, line address width
- DATA_W, 64, fill beat width
- BEATS, 4, beats per line (power of two, ≥2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- hit_valid  in  1  lookup hit event
- hit_set  in  SET_W  set of hit
- hit_way  in  8  one-hot hit way
- miss_valid  in  1  miss request
- miss_ready  out  1  miss accepted when both high
- miss_set  in  SET_W  set of miss
- miss_addr  in  ADDR_W  line address of miss
- way_valid  in  8  valid bits of miss_set, sampled at accept
- mem_req_valid  out  1  burst read request
- mem_req_ready  in  1  request accepted
- mem_req_addr  out  ADDR_W  latched miss_addr
- mem_req_len  out  8  constant BEATS-1
- mem_rsp_valid  in  1  data beat valid (always accepted)
- mem_rsp_data  in  DATA_W  beat data
- mem_rsp_last  in  1  final beat
- fill_wen  out  8  one-hot way write enable
- fill_set  out  SET_W  set being filled
- fill_beat  out  log2(BEATS)  beat index within line
- fill_data  out  DATA_W  beat data, combinational from mem_rsp_data
- done_valid  out  1  one-cycle refill-complete pulse
- done_way  out  8  one-hot victim, valid with done_valid
- busy  out  1  high in any state except IDLE

## Operation
- State: plru[SETS] × 7 bits. Bit 0 is the root: 0 selects ways 0–3, 1 selects ways 4–7. Bit 1 selects within ways 0–3 (0 selects 0–1), bit 2 within 4–7. Bits 3–6 select between way pairs 0/1, 2/3, 4/5, 6/7 (0 selects the even way).
- Victim: walk the tree from the root, following each bit.
- Touch(way): set every bit on the path so that it points away from that way (e.g., way0 sets bits 0, 1, 3 to 1).
- Hit: hit_valid applies touch(hit_way) to plru[hit_set] at the clock edge.
- FSM IDLE→REQ→FILL→DONE→IDLE.
  - IDLE: miss_ready=1. On accept, latch set, addr, and victim, then go to REQ.
  - REQ: mem_req_valid=1 with stable addr/len until mem_req_ready, then go to FILL.
  - FILL: each mem_rsp_valid writes fill_wen=victim and fill_beat=counter, then increments the counter. A beat with mem_rsp_last goes to DONE. Beats after BEATS-1 without last get fill_wen=0 (dropped).
  - DONE: done_valid=1 and done_way=victim. Touch(victim) on the latched set. Return to IDLE.
- Collision: if the DONE update and a hit target the same set in the same cycle, the DONE update wins and the hit is dropped. Different sets are both applied.
- Victim is computed from the registered plru at accept. A hit in the same cycle is not bypassed into the victim choice.
- fill_wen is 0 outside FILL beats.

## Timing
- Reset values:
  - plru all 0, so the first victim is way0.
  - FSM in IDLE; miss_ready=1; busy, mem_req_valid, fill_wen, done_valid all 0.
  - Counter 0; latched set, addr, and victim 0.
- Miss accept at cycle T gives mem_req_valid at T+1.
- Fill write occurs in the same cycle as the beat.
- done_valid is asserted the cycle after the last beat. The next miss can be accepted the cycle after DONE.
- Reset mid-operation aborts immediately with no done pulse; plru clears.

## Configuration
- ICACHE_REFILL_INVALID_FIRST_EN defined: at accept, if any way_valid bit is 0, the victim is the lowest-index invalid way; otherwise the PLRU victim is used. DONE still applies touch(victim).
- ICACHE_REFILL_INVALID_FIRST_EN undefined: way_valid is ignored and the victim is always from PLRU.

## Test plan
- Reset, then miss set 3 addr 0x1000: mem_req_addr=0x1000, mem_req_len=3, four beats with fill_wen=8'h01 and fill_beat 0..3, done_way=8'h01, plru[3]=7'h0B. Next miss to set 3 gives victim 8'h10.
- Eight back-to-back misses to set 9 with no hits: victims in order are ways 0,4,2,6,1,5,3,7.
- After reset, hit set 5 way 8'h01, then miss set 5: victim 8'h10.
- Hold mem_req_ready low for 10 cycles: mem_req_valid and mem_req_addr stay stable, miss_ready=0, busy=1. mem_rsp_last on beat 1: exactly 2 fill writes, then done_valid.
- In the DONE cycle for set 2 (victim way0), drive a hit on set 2 way 8'h10: plru[2]=7'h0B. Same test with the hit on set 7: both updates are applied.
- With the macro defined, way_valid=8'hF7 gives victim 8'h08, and way_valid=8'hFF falls back to the PLRU victim. Without the macro, way_valid=8'hF7 gives victim 8'h01 after reset.
